// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants; PARITY state exists only with UART_TX_PARITY_EN
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;
`endif

    // 100 MHz / 9600 baud, rounded to the nearest whole cycle
    localparam int UART_CLK_DIV_100M_9600 = 10417;

    localparam int UART_PARITY_EVEN = 0;
    localparam int UART_PARITY_ODD  = 1;

    // Narrower words are zero-extended, which leaves the XOR unchanged
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous single-clock FIFO with push/pop/count, shared by TX and a future RX
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count, so a pop in the same cycle never frees a slot early
    assign full_o     = (count_q == FULL_COUNT);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Storage is not reset; the pointers alone decide what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks net occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered UART transmitter; optional parity bit when UART_TX_PARITY_EN is defined
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = UART_CLK_DIV_100M_9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = UART_PARITY_EVEN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          uart_rxd_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx: CLK_DIV must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be 5..8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] fifo_rdata;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (s_valid),
        .push_data_i (s_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign s_ready = !fifo_full;

    uart_state_e          state_q, state_d;
    logic [15:0]          timer_q, timer_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Frame state, bit timer, shifter and the registered line driver
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; the line value is computed from the next state so it lines up with state_q
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        tx_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        bit_end  = (timer_q == BIT_LAST);
        timer_d  = bit_end ? '0 : timer_q + 16'd1;

        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when a word is waiting
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            state_d  = ST_START;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        if (fifo_pop) begin
            shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_d   = uart_parity(8'(fifo_rdata), PARITY_ODD[0]);
`endif
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    assign uart_rxd_out = tx_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: line decoder against a frame-level reference model
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data0;
    logic       s_valid0;
    logic       s_ready0, rxd0, busy0;
    logic [2:0] count0;
    logic [4:0] s_data1;
    logic       s_valid1;
    logic       s_ready1, rxd1, busy1;
    logic [2:0] count1;

    uart_tx #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
        .uart_rxd_out(rxd0), .busy(busy0), .fifo_count(count0));

    uart_tx #(.CLK_DIV(CLK_DIV), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)) dut1 (
        .clk(clk), .reset(reset), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .uart_rxd_out(rxd1), .busy(busy1), .fifo_count(count1));

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_q [2][$];
    bit   in_frame [2];
    int   pos [2];
    logic smp [2][64];
    bit   busy_bad [2];
    int   idle_cnt [2];
    bit   need_nogap [2];
    bit   lat_pending [2];
    int   lat_cyc [2];
    int   frames [2];
    int   last_acc_cnt [2];
    bit   saw_not_ready [2];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int nbits(input int d);
        return (d == 0) ? 8 : 5;
    endfunction

    function automatic int frame_len(input int d);
        return 1 + nbits(d) + PAR_EN + ((d == 0) ? 1 : 2);
    endfunction

    // Reference frame: start 0, data LSB first, optional parity, then stop ones
    function automatic logic exp_bit(input int d, input int data, input int k);
        int nd, ones;
        nd = nbits(d);
        if (k == 0) return 1'b0;
        if (k <= nd) return logic'((data >> (k - 1)) & 1);
        if (PAR_EN == 1 && k == nd + 1) begin
            ones = $countones(data & ((1 << nd) - 1));
            return logic'((ones % 2) ^ ((d == 0) ? 0 : 1));
        end
        return 1'b1;
    endfunction

    task automatic check_frame(input int d);
        int e, nb;
        logic [15:0] gb, eb;
        bit ok;
        nb = frame_len(d);
        n_checks++;
        if (exp_q[d].size() == 0) begin
            n_fail++;
            $display("FAIL frame dut%0d: got an unexpected frame, expected none queued", d);
            return;
        end
        e  = exp_q[d].pop_front();
        ok = !busy_bad[d];
        gb = '0;
        eb = '0;
        for (int k = 0; k < nb; k++) begin
            eb[k] = exp_bit(d, e, k);
            gb[k] = smp[d][k*CLK_DIV];
            for (int j = 1; j < CLK_DIV; j++)
                if (smp[d][k*CLK_DIV+j] !== gb[k]) ok = 0;
        end
        if (gb !== eb) ok = 0;
        if (!ok) begin
            n_fail++;
            $display("FAIL frame dut%0d data 0x%0h: bits got %b expected %b, busy_held %0d, width_ok per bit required",
                     d, e, gb, eb, !busy_bad[d]);
        end
        need_nogap[d] = (exp_q[d].size() > 0);
    endtask

    // Cycle-level line decoder and occupancy scoreboard for one instance
    task automatic mon(input int d, input logic line, input logic bz, input logic rdy,
                       input int cnt, input logic vld, input int data);
        int occ;
        if (in_frame[d]) begin
            smp[d][pos[d]] = line;
            if (!bz) busy_bad[d] = 1;
            pos[d]++;
            if (pos[d] == frame_len(d) * CLK_DIV) begin
                in_frame[d] = 0;
                idle_cnt[d] = 0;
                check_frame(d);
            end
        end else if (line == 1'b0) begin
            in_frame[d] = 1;
            pos[d]      = 1;
            smp[d][0]   = line;
            busy_bad[d] = !bz;
            frames[d]++;
            if (need_nogap[d]) chk($sformatf("no_gap_dut%0d", d), idle_cnt[d], 0);
            need_nogap[d] = 0;
            if (lat_pending[d]) chk($sformatf("start_latency_ok_dut%0d", d), int'((cyc - lat_cyc[d]) <= 3), 1);
            lat_pending[d] = 0;
        end else begin
            idle_cnt[d]++;
            chk($sformatf("idle_busy_dut%0d", d), int'(bz), 0);
        end
        occ = exp_q[d].size() - (in_frame[d] ? 1 : 0);
        chk($sformatf("fifo_count_dut%0d", d), cnt, occ);
        chk($sformatf("s_ready_dut%0d", d), int'(rdy), int'(occ != DEPTH));
        if (!rdy) saw_not_ready[d] = 1;
        if (vld && rdy) begin
            if (occ == 0 && !in_frame[d]) begin
                lat_pending[d] = 1;
                lat_cyc[d]     = cyc;
            end
            exp_q[d].push_back(data);
            last_acc_cnt[d] = cnt;
        end
    endtask

    // Monitor runs on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                exp_q[d].delete();
                in_frame[d]    = 0;
                need_nogap[d]  = 0;
                lat_pending[d] = 0;
                idle_cnt[d]    = 0;
            end
        end else begin
            mon(0, rxd0, busy0, s_ready0, int'(count0), s_valid0, int'(s_data0));
            mon(1, rxd1, busy1, s_ready1, int'(count1), s_valid1, int'(s_data1));
        end
    end

    task automatic send0(input logic [7:0] d);
        int t = 0;
        s_data0  = d;
        s_valid0 = 1'b1;
        @(negedge clk);
        while (!s_ready0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("send0_timeout", t, 0);
        @(posedge clk);
        #1 s_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [4:0] d);
        int t = 0;
        s_data1  = d;
        s_valid1 = 1'b1;
        @(negedge clk);
        while (!s_ready1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("send1_timeout", t, 0);
        @(posedge clk);
        #1 s_valid1 = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int t = 0;
        while ((exp_q[d].size() != 0 || in_frame[d]) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) chk($sformatf("wait_idle_timeout_dut%0d", d), t, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string hello;
        int t, nf;
        hello    = "Hello world!\r\n";
        reset    = 1'b1;
        s_valid0 = 1'b0;
        s_data0  = '0;
        s_valid1 = 1'b0;
        s_data1  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rxd", int'(rxd0), 1);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_count", int'(count0), 0);
        chk("reset_ready", int'(s_ready0), 1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single frame from idle
        send0(8'h48);
        wait_idle(0);

        // Burst with valid held high
        saw_not_ready[0] = 0;
        for (int i = 0; i < hello.len(); i++) send0(hello[i]);
        wait_idle(0);
        chk("burst_ready_toggled", int'(saw_not_ready[0]), 1);

        // Fill to full, then push one more and see when it lands
        send0(8'h01);
        send0(8'h02);
        send0(8'h03);
        send0(8'h04);
        send0(8'h05);
        @(negedge clk);
        chk("full_ready_low", int'(s_ready0), 0);
        chk("full_count", int'(count0), DEPTH);
        @(posedge clk);
        #1;
        send0(8'hAA);
        chk("push_after_full_count", last_acc_cnt[0], DEPTH - 1);
        wait_idle(0);

        // Randomized traffic with random gaps
        for (int i = 0; i < 40; i++) begin
            send0(8'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(posedge clk);
            #1;
        end
        wait_idle(0);

        // Second configuration: 5 data bits, 2 stop bits
        send1(5'h1F);
        wait_idle(1);
        for (int i = 0; i < 8; i++) send1(5'($urandom));
        wait_idle(1);

        // Reset during data bit 3 with two words queued
        send0(8'h55);
        send0(8'h11);
        send0(8'h22);
        t = 0;
        while (!(in_frame[0] && pos[0] >= 4 * CLK_DIV + 1) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("reset_wait_timeout", t, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_rxd", int'(rxd0), 1);
        chk("midreset_busy", int'(busy0), 0);
        chk("midreset_count", int'(count0), 0);
        chk("midreset_ready", int'(s_ready0), 1);
        reset = 1'b0;
        nf = frames[0];
        repeat (150) @(negedge clk);
        chk("no_frames_after_reset", frames[0] - nf, 0);
        chk("line_high_after_reset", int'(rxd0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
